stack_responder: RTL and testbench
==================================

STACK_RESPONDER -- requirements
Module: stack_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5, width of each stack entry.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, RAM address width; capacity 2^ADDR_WIDTH entries.
REQ-003 SHALL have port clock, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high; clock clock.
REQ-005 SHALL have port cmd_valid, input, 1, command offered.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted this cycle when both cmd_valid and cmd_ready are high.
REQ-007 SHALL have port cmd_op, input, 2: 00 CLEAR, 01 PUSH, 10 POP, 11 PEEK.
REQ-008 SHALL have port cmd_data, input, DATA_WIDTH, push operand.
REQ-009 SHALL have port rsp_valid, output, 1, response held stable until taken.
REQ-010 SHALL have port rsp_ready, input, 1, response consumed when rsp_valid and rsp_ready are both high.
REQ-011 SHALL have port rsp_data, output, DATA_WIDTH, popped/peeked value, else 0.
REQ-012 SHALL have port rsp_status, output, 2: 00 OK, 01 EMPTY, 10 FULL.
REQ-013 SHALL have port count, output, ADDR_WIDTH+1, current occupancy.

Function
REQ-014 SHALL implement FSM states IDLE, READ, RESP; cmd_ready high only in IDLE.
REQ-015 SHALL, on PUSH accepted at cycle T with count < capacity, write cmd_data at address count and increment count at T, then enter RESP with status OK and rsp_data 0; rsp_valid first high at T+1.
REQ-016 SHALL, on PUSH when count == capacity, perform no write, leave count unchanged, and respond at T+1 with FULL and rsp_data 0.
REQ-017 SHALL, on POP accepted at T with count > 0, issue a RAM read of address count-1 and decrement count at T, enter READ, then enter RESP with OK and the RAM data; rsp_valid first high at T+2.
REQ-018 SHALL handle PEEK as POP, except that count is unchanged.
REQ-019 SHALL, on POP or PEEK with count == 0, respond at T+1 with EMPTY and rsp_data 0, without a RAM access.
REQ-020 SHALL, on CLEAR, set count to 0 at T and respond at T+1 with OK; RAM contents are not modified.
REQ-021 SHALL leave RESP for IDLE on the cycle rsp_ready is sampled high; the next command may be accepted the following cycle (max throughput 1 command per 2 cycles for push, 3 for pop).
REQ-022 SHALL hold rsp_data and rsp_status stable while rsp_valid is high and rsp_ready is low.
REQ-023 SHALL ignore cmd_* inputs outside IDLE.
REQ-024 SHALL use count arithmetic that never wraps: width is ADDR_WIDTH+1, and the full/empty guards in REQ-016 and REQ-019 take precedence.
REQ-025 SHALL keep RAM write enable low in every cycle except an accepted non-full PUSH.

Reset
REQ-026 SHALL, on reset, force state IDLE, count 0, rsp_valid 0, rsp_data 0, and rsp_status 00; cmd_ready is 1 in the first cycle after reset.
REQ-027 SHALL abandon any command in flight when reset is asserted mid-operation (READ or RESP); no response is emitted for that command.

Structure
REQ-028 SHALL take the op and status encodings from the shared package as named constants.
REQ-029 SHALL instantiate one sub-module, block_ram: single-port, 1-cycle read latency, parameterised by ADDR_WIDTH and DATA_WIDTH; all control stays in stack_responder.

Verification
REQ-030 SHALL cover: after reset, PUSH 5'h03, PUSH 5'h11, then POP, POP -> responses OK/0, OK/0, OK/5'h11, OK/5'h03; count 1,2,1,0.
REQ-031 SHALL cover: POP with count 0 -> EMPTY, rsp_data 0, count stays 0, rsp_valid at T+1.
REQ-032 SHALL cover: 256 PUSHes of value i mod 32, then a 257th PUSH -> FULL, count 256; a following PEEK -> OK with rsp_data 5'h1F.
REQ-033 SHALL cover: PUSH 5'h07, then PEEK with rsp_ready held low for 5 cycles -> rsp_valid, rsp_data 5'h07 and status stable throughout, cmd_ready low throughout, count 1.
REQ-034 SHALL cover: PUSH 3 values, then CLEAR -> OK, count 0; next POP -> EMPTY.
REQ-035 SHALL cover: reset asserted in the cycle after a POP is accepted (state READ) -> no response, count 0, cmd_ready high the cycle after reset deasserts.

Source files
------------

// File: rtl/stack_responder_pkg.sv
// Shared encodings for the stack responder: command ops, response status and FSM states.
// Kept in one place so the responder and any client logic agree on the wire values.
package stack_responder_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_PUSH  = 2'b01,
    OP_POP   = 2'b10,
    OP_PEEK  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_EMPTY = 2'b01,
    ST_FULL  = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_READ = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/stack_responder_block_ram.sv
// Single-port synchronous RAM with one-cycle registered read (read-before-write).
// Pure storage: all sequencing and address generation lives in the parent.
module block_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the array has no reset so it maps onto a RAM macro; only the stack pointer needs one.
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/stack_responder.sv
// LIFO stack behind a valid/ready command port and a held valid/ready response port.
// One command in flight at a time; pops and peeks spend one extra cycle on the RAM read.
module stack_responder
  import stack_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_status,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] CAPACITY  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = '0;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  status_e               rsp_status_q, rsp_status_d;

  logic                  accept;
  logic                  is_full, is_empty;
  logic [ADDR_WIDTH:0]   count_inc, count_dec;

  logic                  ram_en, ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign cmd_ready  = (state_q == S_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign is_full    = (count_q == CAPACITY);
  assign is_empty   = (count_q == '0);
  assign count_inc  = count_q + COUNT_ONE;
  assign count_dec  = count_q - COUNT_ONE;

  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign count      = count_q;

  // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = count_q[ADDR_WIDTH-1:0];

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          rsp_data_d   = DATA_ZERO;
          rsp_status_d = ST_OK;
          state_d      = S_RESP;
          unique case (op_e'(cmd_op))
            OP_CLEAR: count_d = '0;
            OP_PUSH: begin
              if (is_full) begin
                rsp_status_d = ST_FULL;
              end else begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = count_q[ADDR_WIDTH-1:0];
                count_d  = count_inc;
              end
            end
            OP_POP, OP_PEEK: begin
              if (is_empty) begin
                rsp_status_d = ST_EMPTY;
              end else begin
                // Top of stack sits at count-1; a peek reads it without moving the pointer.
                ram_en   = 1'b1;
                ram_addr = count_dec[ADDR_WIDTH-1:0];
                state_d  = S_READ;
                if (op_e'(cmd_op) == OP_POP) count_d = count_dec;
              end
            end
            default: ;
          endcase
        end
      end

      S_READ: begin
        rsp_data_d   = ram_rdata;
        rsp_status_d = ST_OK;
        state_d      = S_RESP;
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d      = S_IDLE;
          rsp_data_d   = DATA_ZERO;
          rsp_status_d = ST_OK;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  block_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clock(clock),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(cmd_data),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_stack_responder.sv
// Directed bench for stack_responder: hand-computed responses, latencies and occupancy.
module tb_stack_responder;
  import stack_responder_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_data;
  logic       rsp_valid, rsp_ready;
  logic [4:0] rsp_data;
  logic [1:0] rsp_status;
  logic [8:0] count;

  int checks = 0;
  int errors = 0;

  stack_responder #(.DATA_WIDTH(5), .ADDR_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one command; returns once it has been accepted at a rising edge.
  task automatic send(input logic [1:0] op, input logic [4:0] data);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  // Wait for the response (latency counted in cycles after acceptance) and consume it.
  task automatic take(output logic [4:0] d, output logic [1:0] s, output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!rsp_valid && lat < 20);
    d = rsp_data;
    s = rsp_status;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic [1:0] op, input logic [4:0] data,
                     input logic [4:0] exp_d, input logic [1:0] exp_s, input int exp_lat,
                     input int exp_cnt);
    logic [4:0] d;
    logic [1:0] s;
    int lat;
    send(op, data);
    take(d, s, lat);
    check({tag, "_lat"},    32'(lat), 32'(exp_lat));
    check({tag, "_data"},   32'(d),   32'(exp_d));
    check({tag, "_status"}, 32'(s),   32'(exp_s));
    check({tag, "_count"},  32'(count), 32'(exp_cnt));
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_status",    32'(rsp_status), 32'd0);
    check("rst_count",     32'(count),     32'd0);

    // Basic LIFO order.
    txn("push03", OP_PUSH, 5'h03, 5'h00, ST_OK, 1, 1);
    txn("push11", OP_PUSH, 5'h11, 5'h00, ST_OK, 1, 2);
    txn("pop11",  OP_POP,  5'h00, 5'h11, ST_OK, 2, 1);
    txn("pop03",  OP_POP,  5'h00, 5'h03, ST_OK, 2, 0);

    // Empty guard.
    txn("pop_empty",  OP_POP,  5'h00, 5'h00, ST_EMPTY, 1, 0);
    txn("peek_empty", OP_PEEK, 5'h00, 5'h00, ST_EMPTY, 1, 0);

    // Fill to capacity, then overflow and peek the top (255 mod 32 = 0x1F).
    for (int i = 0; i < 256; i++) txn("fill", OP_PUSH, 5'(i % 32), 5'h00, ST_OK, 1, i + 1);
    txn("push_full", OP_PUSH, 5'h0A, 5'h00, ST_FULL, 1, 256);
    txn("peek_full", OP_PEEK, 5'h00, 5'h1F, ST_OK,   2, 256);
    txn("pop_full",  OP_POP,  5'h00, 5'h1F, ST_OK,   2, 255);
    txn("peek_1e",   OP_PEEK, 5'h00, 5'h1E, ST_OK,   2, 255);
    txn("clear_big", OP_CLEAR, 5'h00, 5'h00, ST_OK,  1, 0);

    // Response held under backpressure; commands offered meanwhile must be ignored.
    txn("push07", OP_PUSH, 5'h07, 5'h00, ST_OK, 1, 1);
    send(OP_PEEK, 5'h00);
    cmd_valid = 1'b1;
    cmd_op    = OP_CLEAR;
    @(negedge clock);
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid",     32'(rsp_valid),  32'd1);
      check("hold_data",      32'(rsp_data),   32'h07);
      check("hold_status",    32'(rsp_status), 32'(ST_OK));
      check("hold_cmd_ready", 32'(cmd_ready),  32'd0);
      check("hold_count",     32'(count),      32'd1);
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    check("hold_done_count", 32'(count), 32'd1);

    // Clear after several pushes; RAM untouched but stack reads as empty.
    txn("p_a", OP_PUSH, 5'h15, 5'h00, ST_OK, 1, 2);
    txn("p_b", OP_PUSH, 5'h16, 5'h00, ST_OK, 1, 3);
    txn("p_c", OP_PUSH, 5'h17, 5'h00, ST_OK, 1, 4);
    txn("clear", OP_CLEAR, 5'h00, 5'h00, ST_OK, 1, 0);
    txn("pop_after_clear", OP_POP, 5'h00, 5'h00, ST_EMPTY, 1, 0);

    // Reset while a pop is in its READ cycle abandons it.
    txn("p_r", OP_PUSH, 5'h09, 5'h00, ST_OK, 1, 1);
    send(OP_POP, 5'h00);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_count",     32'(count),     32'd0);
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clock);
    end
    txn("post_rst_push", OP_PUSH, 5'h12, 5'h00, ST_OK, 1, 1);
    txn("post_rst_pop",  OP_POP,  5'h00, 5'h12, ST_OK, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
